instr_mem_loadable: RTL
=======================

Name: instr_mem_loadable

Overview:
- Parametrised, loadable instruction memory. Successor of the fixed 8x12 combinational ROM.
- Program is written in through a streaming load port with an auto-incrementing address.
- Fetches are registered, 1-cycle latency, and bounds-checked against the loaded program length.
- Sits between the program loader (testbench/UART) and the processor fetch stage.

Parameters:
- DATA_W, 12, instruction width in bits
- ADDR_W, 3, fetch address width
- DEPTH, 2**ADDR_W, number of words; must be ≤ 2**ADDR_W and ≥ 2

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- load_start  input  1  begin (or restart) a program load
- load_valid  input  1  load_data valid this cycle
- load_last  input  1  marks the final word of the program; qualified by load_valid
- load_data  input  DATA_W  instruction word to store
- load_ready  output  1  block accepts load words; high only in LOAD
- load_done  output  1  one-cycle pulse when a load completes
- fetch_req  input  1  fetch request
- fetch_addr  input  ADDR_W  fetch word address
- fetch_valid  output  1  fetch_data/fetch_err valid this cycle
- fetch_data  output  DATA_W  fetched instruction
- fetch_err  output  1  fetch rejected (not READY or addr ≥ prog_len)
- prog_len  output  ADDR_W+1  number of valid words loaded

Behaviour:
- Reset values, applied on the cycle after reset is sampled high:
  - state = IDLE; wr_ptr = 0; prog_len = 0
  - load_ready = 0; load_done = 0; fetch_valid = 0; fetch_data = 0; fetch_err = 0
  - Memory array is not cleared.
- FSM states: IDLE (no program), LOAD, READY.
- IDLE:
  - load_start -> LOAD on the next cycle; wr_ptr = 0.
  - load_valid is ignored.
- LOAD:
  - load_ready = 1.
  - Accept = load_valid & load_ready: writes mem[wr_ptr] = load_data, then wr_ptr++.
  - An accept with load_last=1, or with wr_ptr==DEPTH-1, ends the load:
    - next state READY
    - prog_len = wr_ptr+1
    - load_done = 1 for exactly one cycle (the cycle READY is entered)
  - At DEPTH words the load ends even if load_last=0; no wrap-around, no overwrite of word 0.
  - load_start in LOAD restarts the load: wr_ptr = 0, state stays LOAD. Restart has priority over a simultaneous load_valid; that word is dropped.
- Entering LOAD from any state clears prog_len to 0.
- READY:
  - load_start -> LOAD as above; load_valid alone is ignored.
- Fetch (every state):
  - fetch_req sampled at edge N -> fetch_valid = 1 in cycle N+1.
  - Hit (state==READY and fetch_addr < prog_len): fetch_data = mem[fetch_addr], fetch_err = 0.
  - Miss (otherwise): fetch_data = 0, fetch_err = 1.
  - Back-to-back fetches are allowed every cycle (throughput 1/cycle).
  - fetch_req low: fetch_valid = 0, fetch_err = 0, fetch_data holds its last value.
  - Fetch concurrent with the completing load write: fetch is evaluated against the pre-edge state. It still errors, since state is LOAD at that edge.
- Reset mid-load: returns to IDLE, prog_len = 0. Partially written words remain in the array but are unfetchable.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then fetch_req with addr 0 -> next cycle fetch_valid=1, fetch_err=1, fetch_data=0.
- load_start, then 3 words 0xA01, 0xB02, 0xC03 (last on 3rd) -> load_done pulses 1 cycle, prog_len=3. Fetch addr 0,1,2 back-to-back -> 0xA01, 0xB02, 0xC03 on consecutive cycles, err=0. Fetch addr 5 -> err=1, data=0.
- Load 8 words with load_last never asserted (DEPTH=8) -> completes after 8th word, prog_len=8. A 9th load_valid is ignored (load_ready=0). Fetch addr 7 returns the 8th word.
- In LOAD after 2 words, assert load_start with load_valid=1, data 0xFFF -> 0xFFF not written, wr_ptr=0. Next words 0x111, 0x222 (last) -> prog_len=2, addr0=0x111.
- Reset asserted after 2 of 4 load words -> state IDLE, prog_len=0, load_ready=0. Fetch addr 0 -> err=1.
- Reload from READY (prog_len=3) with 1 word 0x055 -> prog_len=0 during LOAD; fetches during LOAD err=1. After done: prog_len=1, addr0=0x055, addr1 err=1.

Source files
------------

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: programs stream in through an auto-incrementing
// load port, and fetches are registered and bounds-checked against prog_len.
module instr_mem_loadable #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic              load_last,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic [ADDR_W:0]   prog_len
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W + 1)'(1);

  state_t              state_r, state_nx_s;
  logic [ADDR_W-1:0]   wr_ptr_r;
  logic [ADDR_W:0]     prog_len_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                accept_s, write_s, finish_s;
  logic                load_ready_s, load_done_s, fetch_hit_s;
  logic                load_ready_r, load_done_r, fetch_valid_r, fetch_err_r;
  logic [DATA_W-1:0]   fetch_data_r;

  // Restart wins over a simultaneous load word, which is then dropped.
  assign accept_s = load_valid && (state_r == LOAD);
  assign write_s  = accept_s && !load_start;
  assign finish_s = write_s && (load_last || (wr_ptr_r == LAST_PTR));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_start) state_nx_s = LOAD;
        else            state_nx_s = IDLE;
      end
      LOAD: begin
        if (load_start)    state_nx_s = LOAD;
        else if (finish_s) state_nx_s = READY;
        else               state_nx_s = LOAD;
      end
      READY: begin
        if (load_start) state_nx_s = LOAD;
        else            state_nx_s = READY;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode; every output is registered below, so no input reaches a port directly.
  always_comb begin
    load_ready_s = (state_nx_s == LOAD);
    load_done_s  = finish_s;
    if ((state_r == READY) && ({1'b0, fetch_addr} < prog_len_r)) begin
      fetch_hit_s = 1'b1;
    end else begin
      fetch_hit_s = 1'b0;
    end
  end

  // Write pointer and program length bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      prog_len_r <= '0;
    end else if (load_start) begin
      wr_ptr_r   <= '0;
      prog_len_r <= '0;
    end else if (write_s) begin
      wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (finish_s) prog_len_r <= {1'b0, wr_ptr_r} + LEN_ONE;
    end
  end

  // Program storage; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (write_s) mem_r[wr_ptr_r] <= load_data;
  end

  // Registered load status and fetch response.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_ready_r  <= 1'b0;
      load_done_r   <= 1'b0;
      fetch_valid_r <= 1'b0;
      fetch_err_r   <= 1'b0;
      fetch_data_r  <= '0;
    end else begin
      load_ready_r <= load_ready_s;
      load_done_r  <= load_done_s;
      if (fetch_req) begin
        fetch_valid_r <= 1'b1;
        fetch_err_r   <= !fetch_hit_s;
        fetch_data_r  <= fetch_hit_s ? mem_r[fetch_addr] : '0;
      end else begin
        fetch_valid_r <= 1'b0;
        fetch_err_r   <= 1'b0;
      end
    end
  end

  assign load_ready  = load_ready_r;
  assign load_done   = load_done_r;
  assign fetch_valid = fetch_valid_r;
  assign fetch_err   = fetch_err_r;
  assign fetch_data  = fetch_data_r;
  assign prog_len    = prog_len_r;

endmodule
